// File: rtl/ip_fetch_seq_pkg.sv
// rtl/ip_fetch_seq_pkg.sv - shared encodings for the fetch sequencer
// Purpose: flow-control op codes, sequencer state encoding, the ip_comb
//          select bundle and the op-to-select decode.
// Ports:   none (package)
package ip_fetch_seq_pkg;

   localparam logic [2:0] OP_NEXT = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BZ   = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_JTOS = 3'd4;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      DELIVER = 2'd2
   } state_e;

   typedef struct packed {
      logic ip_skip;
      logic ip_imm_sel;
      logic ip_reg_sel;
      logic ip_tos_sel;
   } ip_sel_t;

   // Reserved op codes (5-7) fall into the default and behave as NEXT.
   function automatic ip_sel_t decode_ctl_op(input logic [2:0] op);
      ip_sel_t s;
      s = '0;
      case (op)
         OP_JMP:  s.ip_imm_sel = 1'b1;
         OP_BZ: begin
            s.ip_skip    = 1'b1;
            s.ip_imm_sel = 1'b1;
         end
         OP_RET:  s.ip_reg_sel = 1'b1;
         OP_JTOS: begin
            s.ip_reg_sel = 1'b1;
            s.ip_tos_sel = 1'b1;
         end
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ip_fetch_seq_ip_comb.sv
// rtl/ip_fetch_seq_ip_comb.sv - next instruction pointer selection
// Purpose: combinational next-IP computation from the select lines.
// Ports:   ip           in  current instruction pointer
//          ip_imm       in  immediate branch target
//          tos          in  top of data stack (low bits)
//          tos_is_zero  in  data-stack top equals zero
//          rstack_top   in  top of return stack
//          ip_skip      in  conditional: take ip_imm only when tos_is_zero
//          ip_imm_sel   in  select immediate target
//          ip_reg_sel   in  select a register source (return stack or TOS)
//          ip_tos_sel   in  with ip_reg_sel, choose TOS over return stack
//          ip_result    out next instruction pointer
module ip_comb #(
   parameter int unsigned iaddr_width = 10
) (
   input  logic [iaddr_width-1:0] ip,
   input  logic [iaddr_width-1:0] ip_imm,
   input  logic [iaddr_width-1:0] tos,
   input  logic                   tos_is_zero,
   input  logic [iaddr_width-1:0] rstack_top,
   input  logic                   ip_skip,
   input  logic                   ip_imm_sel,
   input  logic                   ip_reg_sel,
   input  logic                   ip_tos_sel,
   output logic [iaddr_width-1:0] ip_result
);

   logic [iaddr_width-1:0] ip_inc;

   // Increment wraps naturally at the top of the address space.
   assign ip_inc = ip + {{(iaddr_width-1){1'b0}}, 1'b1};

   always_comb begin
      ip_result = ip_inc;
      if (ip_reg_sel) begin
         ip_result = ip_tos_sel ? tos : rstack_top;
      end else if (ip_imm_sel) begin
         // Conditional branch falls through when the stack top is nonzero.
         ip_result = (ip_skip && !tos_is_zero) ? ip_inc : ip_imm;
      end
   end

endmodule

// File: rtl/ip_fetch_seq.sv
// rtl/ip_fetch_seq.sv - instruction fetch sequencer owning the IP register
// Purpose: fetches one instruction at a time over mem_req/mem_ack, presents
//          it to decode over insn_valid/insn_ready and advances IP using the
//          accepted instruction's flow-control op.
// Ports:   clk, reset                 clock and async active-high reset
//          mem_req, mem_addr          fetch request and address (= IP)
//          mem_ack, mem_rdata         fetch completion and data
//          insn_valid, insn           registered instruction to decode
//          insn_ready                 decode accepts insn
//          IP                         current instruction pointer
//          ctl_op, ctl_imm            flow op and branch target
//          TOS, TOS_is_zero           data-stack top and zero flag
//          rstack_top                 return-stack top
module ip_fetch_seq
   import ip_fetch_seq_pkg::*;
#(
   parameter int unsigned iaddr_width = 10,
   parameter int unsigned insn_width  = 16,
   parameter int unsigned reset_vec   = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   mem_req,
   output logic [iaddr_width-1:0] mem_addr,
   input  logic                   mem_ack,
   input  logic [insn_width-1:0]  mem_rdata,
   output logic                   insn_valid,
   output logic [insn_width-1:0]  insn,
   input  logic                   insn_ready,
   output logic [iaddr_width-1:0] IP,
   input  logic [2:0]             ctl_op,
   input  logic [iaddr_width-1:0] ctl_imm,
   input  logic [iaddr_width-1:0] TOS,
   input  logic                   TOS_is_zero,
   input  logic [iaddr_width-1:0] rstack_top
);

   localparam logic [iaddr_width-1:0] RESET_IP = iaddr_width'(reset_vec);

   state_e                 state_q, state_d;
   logic [iaddr_width-1:0] ip_q, ip_d;
   logic [insn_width-1:0]  insn_q, insn_d;
   ip_sel_t                sel;
   logic [iaddr_width-1:0] ip_result;

   always_comb begin
      sel = decode_ctl_op(ctl_op);
   end

   ip_comb #(
      .iaddr_width (iaddr_width)
   ) u_ip_comb (
      .ip          (ip_q),
      .ip_imm      (ctl_imm),
      .tos         (TOS),
      .tos_is_zero (TOS_is_zero),
      .rstack_top  (rstack_top),
      .ip_skip     (sel.ip_skip),
      .ip_imm_sel  (sel.ip_imm_sel),
      .ip_reg_sel  (sel.ip_reg_sel),
      .ip_tos_sel  (sel.ip_tos_sel),
      .ip_result   (ip_result)
   );

   // mem_ack and insn_ready are only looked at in the state that owns them,
   // so stray handshakes elsewhere (including a late ack in BOOT) are dropped.
   always_comb begin
      state_d    = state_q;
      ip_d       = ip_q;
      insn_d     = insn_q;
      mem_req    = 1'b0;
      insn_valid = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               insn_d  = mem_rdata;
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            insn_valid = 1'b1;
            if (insn_ready) begin
               ip_d    = ip_result;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         ip_q    <= RESET_IP;
         insn_q  <= '0;
      end else begin
         state_q <= state_d;
         ip_q    <= ip_d;
         insn_q  <= insn_d;
      end
   end

   assign mem_addr = ip_q;
   assign IP       = ip_q;
   assign insn     = insn_q;

endmodule

// File: tb/tb_ip_fetch_seq.sv
// tb/tb_ip_fetch_seq.sv - directed self-checking bench for ip_fetch_seq
module tb_ip_fetch_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        insn_valid;
   logic [15:0] insn;
   logic        insn_ready;
   logic [9:0]  ip_o;
   logic [2:0]  ctl_op;
   logic [9:0]  ctl_imm;
   logic [9:0]  tos;
   logic        tos_is_zero;
   logic [9:0]  rstack_top;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ip_fetch_seq #(
      .iaddr_width (10),
      .insn_width  (16),
      .reset_vec   (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .insn_valid  (insn_valid),
      .insn        (insn),
      .insn_ready  (insn_ready),
      .IP          (ip_o),
      .ctl_op      (ctl_op),
      .ctl_imm     (ctl_imm),
      .TOS         (tos),
      .TOS_is_zero (tos_is_zero),
      .rstack_top  (rstack_top)
   );

   function automatic logic [15:0] mem_word(input logic [9:0] a);
      return {6'b101011, a};
   endfunction

   task automatic idle_ctl();
      ctl_op      = 3'd0;
      ctl_imm     = 10'h000;
      tos         = 10'h000;
      tos_is_zero = 1'b0;
      rstack_top  = 10'h000;
   endtask

   // One full instruction: zero-wait fetch, immediate accept with given op.
   task automatic run_insn(input logic [2:0] op, input logic [9:0] imm,
                           input logic [9:0] t, input logic tz,
                           input logic [9:0] rt, output logic [9:0] addr,
                           output logic [15:0] word, output logic ok);
      ok = 1'b1;
      for (int k = 0; k < 20 && mem_req !== 1'b1; k++) @(negedge clk);
      if (mem_req !== 1'b1) ok = 1'b0;
      addr      = mem_addr;
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      if (insn_valid !== 1'b1) ok = 1'b0;
      word        = insn;
      ctl_op      = op;
      ctl_imm     = imm;
      tos         = t;
      tos_is_zero = tz;
      rstack_top  = rt;
      insn_ready  = 1'b1;
      @(negedge clk);
      insn_ready = 1'b0;
      idle_ctl();
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; insn_ready = 1'b0;
      idle_ctl();
      repeat (2) @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
      total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", insn_valid); end
      total++; if (insn !== 16'h0) begin bad++; $display("FAIL rst_insn got=%h want=0000", insn); end
      total++; if (ip_o !== 10'h005) begin bad++; $display("FAIL rst_ip got=%h want=005", ip_o); end
      reset = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", mem_req); end
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 10'h005) begin
         bad++; $display("FAIL first_fetch got=%b/%h want=1/005", mem_req, mem_addr); end
   endtask

   task automatic test_next_stream();
      logic [9:0] exp_addr;
      mem_ack = 1'b1; insn_ready = 1'b1; ctl_op = 3'd0;
      for (int i = 0; i < 7; i++) begin
         mem_rdata = mem_word(mem_addr);
         exp_addr  = 10'h005 + 10'(i / 2);
         total++; if (mem_req !== ((i % 2) == 0)) begin
            bad++; $display("FAIL stream_req[%0d] got=%b want=%b", i, mem_req, (i % 2) == 0); end
         total++; if (insn_valid !== ((i % 2) == 1)) begin
            bad++; $display("FAIL stream_valid[%0d] got=%b want=%b", i, insn_valid, (i % 2) == 1); end
         if ((i % 2) == 0) begin
            total++; if (mem_addr !== exp_addr) begin
               bad++; $display("FAIL stream_addr[%0d] got=%h want=%h", i, mem_addr, exp_addr); end
         end else begin
            total++; if (insn !== mem_word(exp_addr)) begin
               bad++; $display("FAIL stream_insn[%0d] got=%h want=%h", i, insn, mem_word(exp_addr)); end
         end
         if (i < 6) @(negedge clk);
      end
      mem_ack = 1'b0; insn_ready = 1'b0; mem_rdata = 16'h0;
   endtask

   task automatic test_jmp();
      logic [9:0] a; logic [15:0] w; logic ok;
      run_insn(3'd1, 10'h010, 10'h0, 1'b0, 10'h0, a, w, ok);
      total++; if (!ok || a !== 10'h008) begin bad++; $display("FAIL jmp_setup got=%h ok=%b want=008", a, ok); end
      run_insn(3'd1, 10'h200, 10'h0, 1'b0, 10'h0, a, w, ok);
      total++; if (!ok || a !== 10'h010 || w !== mem_word(10'h010)) begin
         bad++; $display("FAIL jmp_fetch got=%h/%h want=010/%h", a, w, mem_word(10'h010)); end
      total++; if (mem_req !== 1'b1 || mem_addr !== 10'h200) begin
         bad++; $display("FAIL jmp_target got=%h want=200", mem_addr); end
   endtask

   task automatic test_bz();
      logic [9:0] a; logic [15:0] w; logic ok;
      run_insn(3'd1, 10'h020, 10'h0, 1'b0, 10'h0, a, w, ok);
      run_insn(3'd2, 10'h100, 10'h000, 1'b1, 10'h0, a, w, ok);
      total++; if (!ok || a !== 10'h020) begin bad++; $display("FAIL bz_fetch got=%h want=020", a); end
      total++; if (mem_addr !== 10'h100) begin bad++; $display("FAIL bz_taken got=%h want=100", mem_addr); end
      run_insn(3'd1, 10'h020, 10'h0, 1'b0, 10'h0, a, w, ok);
      run_insn(3'd2, 10'h100, 10'h055, 1'b0, 10'h0, a, w, ok);
      total++; if (mem_addr !== 10'h021) begin bad++; $display("FAIL bz_not_taken got=%h want=021", mem_addr); end
   endtask

   task automatic test_ret_jtos();
      logic [9:0] a; logic [15:0] w; logic ok;
      run_insn(3'd3, 10'h155, 10'h222, 1'b0, 10'h0AB, a, w, ok);
      total++; if (!ok || mem_addr !== 10'h0AB) begin bad++; $display("FAIL ret got=%h want=0ab", mem_addr); end
      run_insn(3'd4, 10'h155, 10'h3C4, 1'b0, 10'h111, a, w, ok);
      total++; if (!ok || a !== 10'h0AB) begin bad++; $display("FAIL ret_fetch got=%h want=0ab", a); end
      total++; if (mem_addr !== 10'h3C4) begin bad++; $display("FAIL jtos got=%h want=3c4", mem_addr); end
   endtask

   task automatic test_reserved();
      logic [9:0] a; logic [15:0] w; logic ok;
      for (int k = 0; k < 3; k++) begin
         run_insn(3'(5 + k), 10'h155, 10'h2AA, 1'b1, 10'h0CC, a, w, ok);
         total++; if (!ok || mem_addr !== 10'(10'h3C5 + k)) begin
            bad++; $display("FAIL reserved_op%0d got=%h want=%h", 5 + k, mem_addr, 10'(10'h3C5 + k)); end
      end
   endtask

   task automatic test_backpressure();
      // IP is 0x3C7 here; ready asserted while not valid must be ignored.
      mem_ack = 1'b0; insn_ready = 1'b1; ctl_op = 3'd1; ctl_imm = 10'h123;
      for (int k = 0; k < 3; k++) begin
         total++; if (mem_req !== 1'b1 || mem_addr !== 10'h3C7 || insn_valid !== 1'b0) begin
            bad++; $display("FAIL ack_wait[%0d] got=%b/%h/%b want=1/3c7/0", k, mem_req, mem_addr, insn_valid); end
         @(negedge clk);
      end
      insn_ready = 1'b0; idle_ctl();
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      @(negedge clk);
      total++; if (insn_valid !== 1'b1 || insn !== 16'hBEEF || mem_req !== 1'b0) begin
         bad++; $display("FAIL late_ack got=%b/%h/%b want=1/beef/0", insn_valid, insn, mem_req); end
      // Stray acks with different data during DELIVER must not disturb insn.
      mem_rdata = 16'h1234;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++; if (insn_valid !== 1'b1 || insn !== 16'hBEEF || ip_o !== 10'h3C7) begin
            bad++; $display("FAIL ready_wait[%0d] got=%b/%h/%h want=1/beef/3c7", k, insn_valid, insn, ip_o); end
      end
      mem_ack = 1'b0; mem_rdata = 16'h0;
      insn_ready = 1'b1; ctl_op = 3'd0;
      @(negedge clk);
      insn_ready = 1'b0;
      total++; if (mem_req !== 1'b1 || mem_addr !== 10'h3C8 || insn_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release got=%b/%h/%b want=1/3c8/0", mem_req, mem_addr, insn_valid); end
   endtask

   task automatic test_wrap();
      logic [9:0] a; logic [15:0] w; logic ok;
      run_insn(3'd1, 10'h3FF, 10'h0, 1'b0, 10'h0, a, w, ok);
      run_insn(3'd0, 10'h155, 10'h0, 1'b0, 10'h0, a, w, ok);
      total++; if (!ok || a !== 10'h3FF) begin bad++; $display("FAIL wrap_fetch got=%h want=3ff", a); end
      total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL wrap got=%h want=000", mem_addr); end
   endtask

   task automatic test_reset_abort();
      logic [9:0] a; logic [15:0] w; logic ok;
      reset = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0 || ip_o !== 10'h005 || insn_valid !== 1'b0) begin
         bad++; $display("FAIL abort_fetch got=%b/%h/%b want=0/005/0", mem_req, ip_o, insn_valid); end
      @(negedge clk);
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 16'h0;
      total++; if (mem_req !== 1'b1 || mem_addr !== 10'h005 || insn_valid !== 1'b0) begin
         bad++; $display("FAIL stray_ack got=%b/%h/%b want=1/005/0", mem_req, mem_addr, insn_valid); end
      @(negedge clk);
      total++; if (insn_valid !== 1'b0 || mem_req !== 1'b1) begin
         bad++; $display("FAIL stray_hold got=%b/%b want=0/1", insn_valid, mem_req); end
      run_insn(3'd0, 10'h0, 10'h0, 1'b0, 10'h0, a, w, ok);
      total++; if (!ok || a !== 10'h005 || w !== mem_word(10'h005)) begin
         bad++; $display("FAIL refetch got=%h/%h want=005/%h", a, w, mem_word(10'h005)); end
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      @(negedge clk);
      mem_ack = 1'b0;
      reset = 1'b1;
      #1;
      total++; if (insn_valid !== 1'b0 || insn !== 16'h0 || ip_o !== 10'h005) begin
         bad++; $display("FAIL abort_deliver got=%b/%h/%h want=0/0000/005", insn_valid, insn, ip_o); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_next_stream();
      test_jmp();
      test_bz();
      test_ret_jtos();
      test_reserved();
      test_backpressure();
      test_wrap();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ip_fetch_seq.md
Name: ip_fetch_seq

Overview:
- Fetch sequencer that owns the instruction-pointer register.
- Fetches one instruction at a time from instruction memory over a req/ack handshake and hands it to decode over a valid/ready handshake.
- Drives the ip_comb selects from decode's flow-control op to compute the next IP.
- Sits between instruction memory and the decode/execute stage; ip_comb is instantiated inside.

Parameters:
iaddr_width, 10, instruction address width (IP, immediates, rstack_top, TOS slice)
insn_width, 16, instruction word width
reset_vec, 0, IP value loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  instruction fetch request
mem_addr  out  iaddr_width  fetch address; equals IP while mem_req=1
mem_ack  in  1  fetch complete; mem_rdata valid this cycle
mem_rdata  in  insn_width  fetched instruction word
insn_valid  out  1  instruction available to decode
insn  out  insn_width  registered instruction word
insn_ready  in  1  decode accepts insn this cycle
IP  out  iaddr_width  address of the instruction currently held or fetched
ctl_op  in  3  flow op for the accepted insn: 0 NEXT, 1 JMP, 2 BZ, 3 RET, 4 JTOS, 5-7 treated as NEXT
ctl_imm  in  iaddr_width  branch target for JMP/BZ
TOS  in  iaddr_width  top of data stack (low bits)
TOS_is_zero  in  1  data-stack top equals zero
rstack_top  in  iaddr_width  top of return stack

Behaviour:
- Reset (async, active-high): state=BOOT, IP=reset_vec, mem_req=0, insn_valid=0, insn=0. All outputs take these values while reset is high.
- State BOOT: one cycle, outputs idle -> FETCH.
- State FETCH:
  - mem_req=1, mem_addr=IP.
  - Request held until mem_ack, with no time-out.
  - On mem_ack: insn<=mem_rdata -> DELIVER.
  - mem_ack in the same cycle as mem_req first rises is legal (zero-wait memory).
- State DELIVER:
  - mem_req=0, insn_valid=1, insn stable until accepted.
  - On insn_valid&&insn_ready: ctl_op/ctl_imm/TOS/TOS_is_zero/rstack_top are sampled, IP<=ip_result, insn_valid drops next cycle -> FETCH.
  - Without ready, hold indefinitely.
- Select decode into ip_comb (combinational from ctl_op), all others 0:
  - NEXT: no selects.
  - JMP: ip_imm_sel.
  - BZ: ip_skip+ip_imm_sel (TOS nonzero -> IP+1, zero -> ctl_imm).
  - RET: ip_reg_sel.
  - JTOS: ip_reg_sel+ip_tos_sel.
- ip_imm=ctl_imm.
- Arithmetic: IP+1 wraps modulo 2^iaddr_width (all-ones -> 0); no overflow flag.
- Throughput:
  - Minimum 2 cycles per instruction (FETCH with immediate ack, DELIVER with immediate ready).
  - One fetch outstanding max; no prefetch, so branches carry no flush penalty.
- mem_ack outside FETCH: ignored. Decode must not see a spurious insn.
- insn_ready while insn_valid=0: ignored, IP unchanged.
- Reset asserted mid-FETCH or mid-DELIVER:
  - Immediate return to BOOT values.
  - A late mem_ack for the aborted fetch arriving after reset release (in BOOT) is ignored.
- Reserved ctl_op values behave exactly as NEXT.

Decomposition:
- Shared package holds the ctl_op encodings (OP_NEXT..OP_JTOS) and the state encoding (BOOT, FETCH, DELIVER).
- One sub-module: ip_comb, instantiated unmodified for next-IP selection.
- FSM, IP register and insn register live in ip_fetch_seq.

Test Plan:
- Reset with reset_vec=0x005, zero-wait memory, ready tied 1, op NEXT -> mem_addr sequence 0x005, 0x006, 0x007; insn_valid pulses every 2nd cycle.
- JMP: accept insn at IP=0x010 with ctl_op=1, ctl_imm=0x200 -> next mem_addr=0x200.
- BZ at IP=0x020 with ctl_imm=0x100:
  - TOS_is_zero=1 -> 0x100.
  - Repeat with TOS_is_zero=0 -> 0x021.
- RET with rstack_top=0x0AB -> next fetch 0x0AB. JTOS with TOS=0x3C4 -> next fetch 0x3C4.
- Backpressure and wrap:
  - mem_ack delayed 3 cycles -> mem_req/mem_addr stable throughout.
  - insn_ready low 4 cycles -> insn stable, IP unchanged.
  - IP=0x3FF with NEXT -> next fetch 0x000.
- Reset asserted while mem_req=1, then stray mem_ack 1 cycle after release -> outputs idle, insn_valid stays 0, first new fetch at reset_vec.
